// File: rtl/xix_prefix_sequencer.sv
// xix_prefix_sequencer
//   Tracks the active DD/FD index prefix (last prefix wins) and runs the
//   DD/FD CB d op four-byte sequence, capturing the displacement and the CB
//   opcode. Generates the 5-bit phase count XPT/notXPT for the XIX decoders
//   and owns the CM1/CMR cycle-type flags.
//
// Handshake: nothing here is valid/ready. The fetch unit qualifies every
//   input with a one-cycle `step` strobe. When step=0 all other inputs are
//   ignored and no state changes. fetch_done marks that Data holds a
//   completed byte in that T-state.
//
// Ports:
//   CLK, notReset          clock, asynchronous active-low reset
//   step                   T-state advance strobe
//   fetch_done, Data       byte completed this T-state, and its value
//   PR_Reset_XPT           decoder: clear the phase counter
//   P2_Set_CM1/P2_Set_CMR  decoder: next cycle is an M1 fetch / an operand read
//   P2_Reset_XIX/XIY       decoder: drop the prefix
//   P2_Set_XIX4_0/XIY4_0   decoder: enter the CB-displacement sequence
//   XPT, notXPT            phase count and its registered inverse
//   is_Y                   0 = IX, 1 = IY
//   xix_enable             high in PFX; xix4_enable high in X4E
//   CM1, CMR               cycle-type flags, never both 1
//   Disp, CB_Op            captured displacement and CB opcode
//   xpt_overflow           sticky saturation flag, cleared only by reset
//   fsm_state              current sequencer state, for observation
module xix_prefix_sequencer #(
  parameter int XPT_MAX = 31
) (
  input  logic       CLK,
  input  logic       notReset,
  input  logic       step,
  input  logic       fetch_done,
  input  logic [7:0] Data,
  input  logic       PR_Reset_XPT,
  input  logic       P2_Set_CM1,
  input  logic       P2_Set_CMR,
  input  logic       P2_Reset_XIX,
  input  logic       P2_Reset_XIY,
  input  logic       P2_Set_XIX4_0,
  input  logic       P2_Set_XIY4_0,
  output logic [4:0] XPT,
  output logic [4:0] notXPT,
  output logic       is_Y,
  output logic       xix_enable,
  output logic       xix4_enable,
  output logic       CM1,
  output logic       CMR,
  output logic [7:0] Disp,
  output logic [7:0] CB_Op,
  output logic       xpt_overflow,
  output logic [2:0] fsm_state
);

  typedef enum logic [2:0] {
    NONE = 3'd0,
    PFX  = 3'd1,
    X4D  = 3'd2,
    X4O  = 3'd3,
    X4E  = 3'd4
  } state_t;

  localparam logic [4:0] XPT_TOP = 5'(XPT_MAX);

  state_t     state, state_next;
  logic       is_y_next, cm1_next, cmr_next, ovf_next;
  logic [4:0] xpt_next;
  logic [7:0] disp_next, cb_op_next;
  logic       pfx, drop, enter_x4;

  // A prefix byte only counts when it arrives in an M1 opcode fetch.
  assign pfx  = fetch_done & CM1 & ((Data == 8'hDD) | (Data == 8'hFD));
  assign drop = P2_Reset_XIX | P2_Reset_XIY;

  assign fsm_state = state;

  always_comb begin
    state_next = state;
    is_y_next  = is_Y;
    disp_next  = Disp;
    cb_op_next = CB_Op;
    cm1_next   = CM1;
    cmr_next   = CMR;
    ovf_next   = xpt_overflow;
    xpt_next   = XPT;
    enter_x4   = 1'b0;

    if (step) begin
      case (state)
        NONE: begin
          if (pfx) begin
            state_next = PFX;
            is_y_next  = Data[5];
          end
        end
        PFX: begin
          // Dropping the prefix beats entering the CB sequence, which beats
          // reloading the prefix.
          if (drop) begin
            state_next = NONE;
          end else if (P2_Set_XIY4_0) begin
            state_next = X4D;
            is_y_next  = 1'b1;
          end else if (P2_Set_XIX4_0) begin
            state_next = X4D;
            is_y_next  = 1'b0;
          end else if (pfx) begin
            is_y_next = Data[5];
          end
        end
        X4D: begin
          if (fetch_done) begin
            state_next = X4O;
            disp_next  = Data;
          end
        end
        X4O: begin
          if (fetch_done) begin
            state_next = X4E;
            cb_op_next = Data;
          end
        end
        X4E: begin
          if (drop) state_next = NONE;
        end
        default: state_next = NONE;
      endcase

      enter_x4 = (state_next != state) &&
                 ((state_next == X4D) || (state_next == X4O) || (state_next == X4E));

      if (PR_Reset_XPT || pfx) begin
        xpt_next = 5'd0;
      end else if (enter_x4) begin
        xpt_next = 5'd0;
      end else if (XPT == XPT_TOP) begin
        ovf_next = 1'b1;
      end else begin
        xpt_next = XPT + 5'd1;
      end

      // CM1: set wins over the fetch_done clear. A CMR set also clears CM1
      // so the two flags stay mutually exclusive; a CM1 set clears CMR.
      if (P2_Set_CM1) begin
        cm1_next = 1'b1;
        cmr_next = 1'b0;
      end else begin
        if (P2_Set_CMR) begin
          cm1_next = 1'b0;
          cmr_next = 1'b1;
        end else begin
          if (fetch_done && CM1) cm1_next = 1'b0;
          if (fetch_done && (state == X4O)) cmr_next = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge notReset) begin
    if (!notReset) begin
      state        <= NONE;
      is_Y         <= 1'b0;
      Disp         <= 8'h00;
      CB_Op        <= 8'h00;
      CM1          <= 1'b1;
      CMR          <= 1'b0;
      XPT          <= 5'd0;
      notXPT       <= 5'b11111;
      xpt_overflow <= 1'b0;
      xix_enable   <= 1'b0;
      xix4_enable  <= 1'b0;
    end else begin
      state        <= state_next;
      is_Y         <= is_y_next;
      Disp         <= disp_next;
      CB_Op        <= cb_op_next;
      CM1          <= cm1_next;
      CMR          <= cmr_next;
      XPT          <= xpt_next;
      notXPT       <= ~xpt_next;
      xpt_overflow <= ovf_next;
      // Enables come straight from flops so they cannot glitch.
      xix_enable   <= (state_next == PFX);
      xix4_enable  <= (state_next == X4E);
    end
  end

endmodule

// File: tb/tb_xix_prefix_sequencer.sv
module tb_xix_prefix_sequencer;

  localparam logic [2:0] S_NONE = 3'd0;
  localparam logic [2:0] S_PFX  = 3'd1;
  localparam logic [2:0] S_X4D  = 3'd2;
  localparam logic [2:0] S_X4O  = 3'd3;
  localparam logic [2:0] S_X4E  = 3'd4;

  logic       clk;
  logic       rst_n;
  logic       step;
  logic       fetch_done;
  logic [7:0] data;
  logic       pr_reset_xpt, set_cm1, set_cmr;
  logic       reset_xix, reset_xiy, set_xix4, set_xiy4;
  logic [4:0] xpt, not_xpt;
  logic       is_y, xix_en, xix4_en, cm1, cmr, ovf;
  logic [7:0] disp, cb_op;
  logic [2:0] fsm_state;

  int n_checks = 0;
  int n_pass   = 0;

  xix_prefix_sequencer dut (
    .CLK          (clk),
    .notReset     (rst_n),
    .step         (step),
    .fetch_done   (fetch_done),
    .Data         (data),
    .PR_Reset_XPT (pr_reset_xpt),
    .P2_Set_CM1   (set_cm1),
    .P2_Set_CMR   (set_cmr),
    .P2_Reset_XIX (reset_xix),
    .P2_Reset_XIY (reset_xiy),
    .P2_Set_XIX4_0(set_xix4),
    .P2_Set_XIY4_0(set_xiy4),
    .XPT          (xpt),
    .notXPT       (not_xpt),
    .is_Y         (is_y),
    .xix_enable   (xix_en),
    .xix4_enable  (xix4_en),
    .CM1          (cm1),
    .CMR          (cmr),
    .Disp         (disp),
    .CB_Op        (cb_op),
    .xpt_overflow (ovf),
    .fsm_state    (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic idle_inputs();
    step = 1'b0; fetch_done = 1'b0; data = 8'h00;
    pr_reset_xpt = 1'b0; set_cm1 = 1'b0; set_cmr = 1'b0;
    reset_xix = 1'b0; reset_xiy = 1'b0; set_xix4 = 1'b0; set_xiy4 = 1'b0;
  endtask

  // Apply the currently driven inputs on one rising edge, sample 1 ns later,
  // then return all inputs to idle.
  task automatic tick();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic do_step();
    step = 1'b1;
    tick();
  endtask

  task automatic fetch(input logic [7:0] b);
    fetch_done = 1'b1;
    data = b;
    do_step();
  endtask

  task automatic do_reset();
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, 32'(fsm_state), 32'(S_NONE));
    check({tag, "_xpt"},   32'(xpt), 32'd0);
    check({tag, "_nxpt"},  32'(not_xpt), 32'h1f);
    check({tag, "_isy"},   32'(is_y), 32'd0);
    check({tag, "_cm1"},   32'(cm1), 32'd1);
    check({tag, "_cmr"},   32'(cmr), 32'd0);
    check({tag, "_disp"},  32'(disp), 32'h00);
    check({tag, "_cbop"},  32'(cb_op), 32'h00);
    check({tag, "_xen"},   32'(xix_en), 32'd0);
    check({tag, "_x4en"},  32'(xix4_en), 32'd0);
    check({tag, "_ovf"},   32'(ovf), 32'd0);
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    #12;
    check_reset_values("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // ---- prefix entry and phase count ----
    fetch_done = 1'b1; data = 8'hDD;   // step=0: must be ignored
    tick();
    check("nostep_state", 32'(fsm_state), 32'(S_NONE));
    check("nostep_cm1", 32'(cm1), 32'd1);

    fetch(8'hDD);
    check("dd_state", 32'(fsm_state), 32'(S_PFX));
    check("dd_isy", 32'(is_y), 32'd0);
    check("dd_xen", 32'(xix_en), 32'd1);
    check("dd_xpt", 32'(xpt), 32'd0);
    check("dd_cm1", 32'(cm1), 32'd0);
    for (int i = 0; i < 3; i++) do_step();
    check("cnt3_xpt", 32'(xpt), 32'd3);
    check("cnt3_nxpt", 32'(not_xpt), 32'b11100);

    // ---- DD FD DD FD chain, last prefix wins ----
    set_cm1 = 1'b1;
    do_step();
    check("chain_cm1", 32'(cm1), 32'd1);
    begin
      logic [7:0] chain [4];
      chain[0] = 8'hDD; chain[1] = 8'hFD; chain[2] = 8'hDD; chain[3] = 8'hFD;
      for (int i = 0; i < 4; i++) begin
        set_cm1 = 1'b1;   // set wins over the fetch_done clear
        fetch(chain[i]);
        check($sformatf("chain%0d_isy", i), 32'(is_y), 32'(chain[i][5]));
        check($sformatf("chain%0d_xpt", i), 32'(xpt), 32'd0);
      end
    end
    check("chain_state", 32'(fsm_state), 32'(S_PFX));

    // ---- DD CB d op ----
    do_reset();
    fetch(8'hDD);
    check("cb_pfx_state", 32'(fsm_state), 32'(S_PFX));
    set_xix4 = 1'b1; set_cmr = 1'b1;
    fetch(8'hCB);
    check("cb_x4d_state", 32'(fsm_state), 32'(S_X4D));
    check("cb_x4d_xpt", 32'(xpt), 32'd0);
    check("cb_x4d_cmr", 32'(cmr), 32'd1);
    check("cb_x4d_cm1", 32'(cm1), 32'd0);
    check("cb_x4d_xen", 32'(xix_en), 32'd0);
    reset_xiy = 1'b1;                  // ignored in X4D
    fetch(8'h85);
    check("cb_x4o_state", 32'(fsm_state), 32'(S_X4O));
    check("cb_disp", 32'(disp), 32'h85);
    check("cb_x4o_cmr", 32'(cmr), 32'd1);
    reset_xix = 1'b1;                  // ignored in X4O
    fetch(8'h46);
    check("cb_x4e_state", 32'(fsm_state), 32'(S_X4E));
    check("cb_op", 32'(cb_op), 32'h46);
    check("cb_x4e_en", 32'(xix4_en), 32'd1);
    check("cb_x4e_xpt", 32'(xpt), 32'd0);
    check("cb_x4e_cmr", 32'(cmr), 32'd0);
    check("cb_x4e_isy", 32'(is_y), 32'd0);
    do_step();
    check("cb_x4e_xpt1", 32'(xpt), 32'd1);
    reset_xix = 1'b1;
    do_step();
    check("cb_end_state", 32'(fsm_state), 32'(S_NONE));
    check("cb_end_x4en", 32'(xix4_en), 32'd0);

    // ---- reset-prefix coincident with pfx ----
    do_reset();
    fetch(8'hDD);
    set_cm1 = 1'b1;
    do_step();
    reset_xiy = 1'b1;
    fetch(8'hDD);
    check("drop_state", 32'(fsm_state), 32'(S_NONE));
    check("drop_xen", 32'(xix_en), 32'd0);
    check("drop_isy", 32'(is_y), 32'd0);

    // ---- saturation ----
    do_reset();
    fetch(8'hDD);
    for (int i = 0; i < 31; i++) do_step();
    check("sat31_xpt", 32'(xpt), 32'd31);
    check("sat31_ovf", 32'(ovf), 32'd0);
    do_step();
    check("sat32_ovf", 32'(ovf), 32'd1);
    for (int i = 0; i < 8; i++) do_step();
    check("sat40_xpt", 32'(xpt), 32'd31);
    check("sat40_nxpt", 32'(not_xpt), 32'd0);
    check("sat40_state", 32'(fsm_state), 32'(S_PFX));
    pr_reset_xpt = 1'b1;
    do_step();
    check("satclr_xpt", 32'(xpt), 32'd0);
    check("satclr_nxpt", 32'(not_xpt), 32'h1f);
    check("satclr_ovf", 32'(ovf), 32'd1);

    // ---- async reset mid-X4O; both sets -> IY wins ----
    do_reset();
    fetch(8'hDD);
    set_xix4 = 1'b1; set_xiy4 = 1'b1; set_cmr = 1'b1;
    fetch(8'hCB);
    check("both_isy", 32'(is_y), 32'd1);
    fetch(8'h12);
    check("ar_x4o_state", 32'(fsm_state), 32'(S_X4O));
    check("ar_disp", 32'(disp), 32'h12);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_values("arst");
    #2;
    rst_n = 1'b1;
    tick();
    check("post_arst_state", 32'(fsm_state), 32'(S_NONE));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
